// File: rtl/dadda_seq_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier and its 16x16 core.
package dadda_seq_pkg;

   localparam int unsigned HALF_W = 16;
   localparam int unsigned FULL_W = 32;
   localparam int unsigned PROD_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [FULL_W-1:0] a;
      logic [FULL_W-1:0] b;
   } operands_t;

   // Left shift applied to the partial product of step k.
   localparam int unsigned STEP_SHIFT [4] = '{0, HALF_W, HALF_W, FULL_W};

   // Step j (1..3) contributes only when both selected halves are nonzero.
   function automatic logic step_live(operands_t o, logic [1:0] j);
      logic [HALF_W-1:0] x;
      logic [HALF_W-1:0] y;
      x = j[1] ? o.a[FULL_W-1:HALF_W] : o.a[HALF_W-1:0];
      y = j[0] ? o.b[FULL_W-1:HALF_W] : o.b[HALF_W-1:0];
      return (x != '0) && (y != '0);
   endfunction

endpackage

// File: rtl/dadda_multiplier.sv
// Combinational 16x16 unsigned multiplier: partial products reduced through a
// carry-save compressor array, then one carry-propagate add.
module dadda_multiplier
   import dadda_seq_pkg::*;
(
   input  logic [HALF_W-1:0] x,
   input  logic [HALF_W-1:0] y,
   output logic [FULL_W-1:0] p
);

   logic [FULL_W-1:0] s;
   logic [FULL_W-1:0] c;
   logic [FULL_W-1:0] pp;
   logic [FULL_W-1:0] t;

   // Truncation to 32 bits is exact since the product always fits.
   always_comb begin
      s  = '0;
      c  = '0;
      pp = '0;
      t  = '0;
      for (int i = 0; i < int'(HALF_W); i++) begin
         pp = y[i] ? (FULL_W'(x) << i) : '0;
         t  = s ^ c ^ pp;
         c  = ((s & c) | (s & pp) | (c & pp)) << 1;
         s  = t;
      end
      p = s + c;
   end

endmodule

// File: rtl/dadda_mul32_seq.sv
// 32x32 unsigned multiplier sequenced over four 16x16 partial products through
// one shared combinational core, with valid/ready on both sides.
module dadda_mul32_seq
   import dadda_seq_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FULL_W-1:0] in_a,
   input  logic [FULL_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic              busy
);

   state_t            state;
   state_t            state_d;
   operands_t         ops_q;
   operands_t         ops_d;
   logic [PROD_W-1:0] acc_q;
   logic [PROD_W-1:0] acc_d;
   logic [1:0]        k_q;
   logic [1:0]        k_d;
   logic [1:0]        k_next;
   logic              last_step;
   logic [HALF_W-1:0] mx;
   logic [HALF_W-1:0] my;
   logic [FULL_W-1:0] mp;

   // Operand mux sees only the step counter and captured operands.
   always_comb begin
      mx = k_q[1] ? ops_q.a[FULL_W-1:HALF_W] : ops_q.a[HALF_W-1:0];
      my = k_q[0] ? ops_q.b[FULL_W-1:HALF_W] : ops_q.b[HALF_W-1:0];
   end

   dadda_multiplier u_core (
      .x (mx),
      .y (my),
      .p (mp)
   );

   // Next step selection; early exit picks the lowest remaining live step.
   always_comb begin
      k_next    = k_q + 2'd1;
      last_step = (k_q == 2'd3);
      if (EARLY_EXIT) begin
         last_step = 1'b1;
         for (int j = 3; j >= 1; j--) begin
            if (j > int'(k_q) && step_live(ops_q, 2'(j))) begin
               k_next    = 2'(j);
               last_step = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ops_q <= '0;
         acc_q <= '0;
         k_q   <= '0;
      end else begin
         state <= state_d;
         ops_q <= ops_d;
         acc_q <= acc_d;
         k_q   <= k_d;
      end
   end

   always_comb begin
      state_d  = state;
      ops_d    = ops_q;
      acc_d    = acc_q;
      k_d      = k_q;
      in_ready = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         STEP: begin
            acc_d = acc_q + (PROD_W'(mp) << STEP_SHIFT[k_q]);
            k_d   = k_next;
            if (last_step) state_d = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (in_valid && in_ready) begin
         ops_d.a = in_a;
         ops_d.b = in_b;
         acc_d   = '0;
         k_d     = 2'd0;
         state_d = STEP;
      end
   end

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_p     = acc_q;

endmodule

// File: doc/dadda_mul32_seq.md
# dadda_mul32_seq

Multi-cycle 32x32 unsigned multiplier sequencer built around one 16x16 `dadda_multiplier` instance. The block accepts a 32-bit operand pair over a valid/ready handshake. It steps the four 16x16 partial products through the shared combinational multiplier and accumulates them shift-aligned into a 64-bit result. The result is presented on a valid/ready output port. It sits between a requesting datapath stage and the existing combinational Dadda core, trading latency for area.

## Interface
- `EARLY_EXIT`, default 0: when 1, skip steps 1–3 whose selected operand halves contain a zero half; when 0, latency is fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in 32: multiplicand, unsigned.
- `in_b` in 32: multiplier, unsigned.
- `out_valid` out 1: `out_p` holds a completed product.
- `out_ready` in 1: consumer accepts `out_p`.
- `out_p` out 64: product `in_a*in_b`.
- `busy` out 1: high in STEP or DONE.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - STEP: 2-bit step counter `k`.
  - DONE: `out_valid` = 1.
- Acceptance: when `in_valid && in_ready`, register `in_a`/`in_b` into `a_q`/`b_q`, clear the 64-bit accumulator, set `k` = 0 and enter STEP. Later changes on `in_a`/`in_b` have no effect.
- Steps, each adding product P = mult(x,y) (32 bits, zero-extended) to the accumulator:
  - k=0: x=`a_q[15:0]`, y=`b_q[15:0]`, acc += P.
  - k=1: x=`a_q[15:0]`, y=`b_q[31:16]`, acc += P<<16.
  - k=2: x=`a_q[31:16]`, y=`b_q[15:0]`, acc += P<<16.
  - k=3: x=`a_q[31:16]`, y=`b_q[31:16]`, acc += P<<32.
- Accumulator arithmetic: 64-bit, modulo 2^64. Overflow cannot occur for unsigned operands.
- Step sequencing, EARLY_EXIT=0: k advances 0→1→2→3, then the block enters DONE.
- Step sequencing, EARLY_EXIT=1:
  - Step 0 is always performed.
  - After each step, jump to the next higher k whose x and y halves are both nonzero.
  - If no such k remains, enter DONE.
- DONE: `out_p` = accumulator, `out_valid` = 1.
  - `out_p` and `out_valid` stay stable until `out_valid && out_ready`.
  - On that edge, go to IDLE. If `in_valid` is also high on that edge, accept the new pair and go directly to STEP.
- `in_ready` = IDLE || (DONE && `out_ready`). It is combinational from `out_ready` only.
- Multiplier operand mux is driven from `k` and the registered operands only. There are no combinational paths from `in_*` to the multiplier.
- Reset mid-operation: the in-flight operation is discarded and its result is never presented.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1.
  - `out_valid` = 0, `busy` = 0.
  - `out_p` = 0, accumulator = 0, `k` = 0.
- Latency: acceptance edge E0. N step edges follow (E1..EN), with N = 4 when EARLY_EXIT=0 and N in 1..4 when EARLY_EXIT=1. `out_valid` is high in the cycle after EN.
- Throughput: with `out_ready` held high and `in_valid` continuous, one result every N+1 cycles (5 when EARLY_EXIT=0).
- Backpressure: while DONE && !`out_ready`, `in_ready` = 0 and no operand is captured.
- `rst` dominates every transition on the same edge.

## Structure
- Shared package `dadda_seq_pkg` holds:
  - the state enum {IDLE, STEP, DONE};
  - constants HALF_W=16, FULL_W=32, PROD_W=64;
  - step shift amounts {0,16,16,32}.
- Exactly one `dadda_multiplier` sub-module instance, with inputs driven by the step mux.
- The FSM, operand registers, accumulator and handshake logic are in this block.

## Test plan
- EARLY_EXIT=0, `in_a`=`in_b`=0xFFFFFFFF, `out_ready`=1:
  - `out_p`=0xFFFFFFFE00000001;
  - `out_valid` exactly 4 cycles after acceptance, for 1 cycle.
- EARLY_EXIT=1, `in_a`=`in_b`=0x00010000:
  - `out_p`=0x0000000100000000;
  - N=2 (steps 0,3), so `out_valid` 2 cycles after acceptance.
- EARLY_EXIT=1, `in_a`=0x0000FFFF, `in_b`=0xFFFF0000:
  - `out_p`=0x0000FFFE00010000;
  - N=2 (steps 0,1).
- Back-to-back, `out_ready`=1, `in_valid` continuous with 3×5 then 7×9:
  - results 15 then 63;
  - the second pair is accepted on the same edge the first result handshakes;
  - result period 5 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles after 0x12×0x34.
  - `out_p`=0x3A8 stays stable and `in_ready`=0;
  - a new pair offered meanwhile is accepted only on the `out_ready` edge.
- Reset during step k=2 of 0xFFFFFFFF×2:
  - next cycle `out_valid`=0, `in_ready`=1, `out_p`=0;
  - a following 6×7 returns 42.
